// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side bundle between the UART receiver and its consumer.
// master drives the serial line, enable and ack; slave is the receiver itself.
interface uart_rx_if;
  logic       ena;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic       parity_err;

  modport master (
    output ena, rx, ack,
    input  data, valid, frame_err, overrun, busy, parity_err
  );

  modport slave (
    input  ena, rx, ack,
    output data, valid, frame_err, overrun, busy, parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, LSB-first assembly,
// one-cycle valid / frame_err strobes and a sticky overrun flag.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
// CLKS_PER_BIT must be even and >= 4; 2**CNT_W must exceed CLKS_PER_BIT.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TICK_ONE  = CNT_W'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t           state_reg, state_next;
  logic             rx_meta_reg, rx_s_reg;
  logic [CNT_W-1:0] tick_reg, tick_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             frame_err_reg, frame_err_next;
  logic             pending_reg, pending_next;
  logic             overrun_reg, overrun_next;
  logic             accept_byte;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_reg, par_bad_next;
  logic             parity_err_reg, parity_err_next;
`endif

  // Two-flop synchronizer; the line idles high so both flops reset to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= bus.rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      tick_reg       <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      data_reg       <= 8'h00;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      pending_reg    <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      tick_reg       <= tick_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      frame_err_reg  <= frame_err_next;
      pending_reg    <= pending_next;
      overrun_reg    <= overrun_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= par_bad_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  // Next-state logic: walk the frame, sampling rx_s when the tick counter
  // reaches mid-bit, and decide the strobes one cycle ahead of their output.
  always_comb begin
    state_next     = state_reg;
    tick_next      = tick_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
    pending_next   = pending_reg;
    overrun_next   = overrun_reg;
    accept_byte    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next    = par_bad_reg;
    parity_err_next = 1'b0;
`endif

    if (bus.ack) begin
      pending_next = 1'b0;
      overrun_next = 1'b0;
    end

    if (!bus.ena) begin
      state_next = IDLE;
      tick_next  = '0;
      bit_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!rx_s_reg) begin
            state_next = START;
            tick_next  = '0;
          end
        end
        START: begin
          if (tick_reg == HALF_LAST) begin
            tick_next  = '0;
            bit_next   = '0;
            // A start bit that is high again at mid-bit was only a glitch.
            state_next = rx_s_reg ? IDLE : DATA;
          end else begin
            tick_next = tick_reg + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_reg == BIT_LAST) begin
            tick_next           = '0;
            shift_next[bit_reg] = rx_s_reg;
            if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_next = bit_reg + 3'd1;
            end
          end else begin
            tick_next = tick_reg + TICK_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_reg == BIT_LAST) begin
            tick_next    = '0;
            par_bad_next = (^shift_reg) ^ rx_s_reg;
            state_next   = STOP;
          end else begin
            tick_next = tick_reg + TICK_ONE;
          end
        end
`endif
        STOP: begin
          if (tick_reg == BIT_LAST) begin
            tick_next = '0;
            if (rx_s_reg) begin
              state_next = IDLE;
`ifdef UART_RX_PARITY_EN
              parity_err_next = par_bad_reg;
              accept_byte     = !par_bad_reg;
`else
              accept_byte     = 1'b1;
`endif
            end else begin
              frame_err_next = 1'b1;
              state_next     = BREAK;
            end
          end else begin
            tick_next = tick_reg + TICK_ONE;
          end
        end
        BREAK: begin
          if (rx_s_reg) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    // A new byte wins over a simultaneous ack: it stays pending, no overrun.
    if (accept_byte) begin
      data_next    = shift_reg;
      valid_next   = 1'b1;
      pending_next = 1'b1;
      if (pending_reg && !bus.ack) overrun_next = 1'b1;
    end
  end

  assign bus.data      = data_reg;
  assign bus.valid     = valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_reg;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
